// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
//   Serial bit-pattern transmitter. Latches a pattern of up to PAT_W bits and
//   sends it MSB-first (bit pat_len-1 first), one bit per clock. The pattern is
//   repeated 'reps' times, with an optional idle gap of 'gap' cycles between
//   repetitions. This is the sending end of the x-stream consumed by the Moore
//   sequence detectors, and it also serves as a framing-pattern sender.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        transfer request, sampled only in IDLE
//   pattern      bits to send; bit pat_len-1 goes out first
//   pat_len      bits per repetition; 0 or > PAT_W means PAT_W
//   reps         repetition count; 0 sends nothing and only pulses done
//   gap          idle cycles between repetitions (none after the last one)
//   abort        synchronous cancel from any state, no done pulse
//   ser_out      serial data, forced to 0 whenever ser_valid is 0
//   ser_valid    ser_out carries a pattern bit
//   frame_start  high together with the first bit of every repetition
//   busy         high from the cycle after acceptance until the done cycle
//   done         one-cycle pulse after the last bit of the last repetition
// -----------------------------------------------------------------------------
module seq_pattern_tx #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] pat_len,
  input  logic [CNT_W-1:0] reps,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;
  logic [CNT_W-1:0] reps_q;   // repetitions still to send, including the current one
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_cnt;  // gap cycles left, including the current one
  logic [LEN_W-1:0] start_len;

  // Out-of-range lengths fall back to the full pattern width.
  function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] l);
    if (l == '0 || l > LEN_MAX)
      return LEN_MAX;
    return l;
  endfunction

  // Shift-based select keeps the index width independent of PAT_W.
  function automatic logic bit_at(input logic [PAT_W-1:0] p,
                                  input logic [LEN_W-1:0] i);
    logic [PAT_W-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  assign start_len = eff_len(pat_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pat_q       <= '0;
      len_q       <= '0;
      idx         <= '0;
      reps_q      <= '0;
      gap_q       <= '0;
      gap_cnt     <= '0;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      // Abort beats everything, including a simultaneous start in IDLE.
      state       <= IDLE;
      ser_out     <= 1'b0;
      ser_valid   <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ser_out     <= 1'b0;
          ser_valid   <= 1'b0;
          frame_start <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
          if (start) begin
            pat_q  <= pattern;
            len_q  <= start_len;
            reps_q <= reps;
            gap_q  <= gap;
            if (reps != '0) begin
              // First bit is driven straight from the inputs being latched.
              state       <= SEND;
              idx         <= start_len - LEN_ONE;
              ser_out     <= bit_at(pattern, start_len - LEN_ONE);
              ser_valid   <= 1'b1;
              frame_start <= 1'b1;
              busy        <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        SEND: begin
          frame_start <= 1'b0;
          if (idx != '0) begin
            idx     <= idx - LEN_ONE;
            ser_out <= bit_at(pat_q, idx - LEN_ONE);
          end else if (reps_q == CNT_ONE) begin
            state     <= DONE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            reps_q <= reps_q - CNT_ONE;
            if (gap_q != '0) begin
              state     <= GAP;
              gap_cnt   <= gap_q;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
            end else begin
              // Back-to-back repetition, no bubble.
              idx         <= len_q - LEN_ONE;
              ser_out     <= bit_at(pat_q, len_q - LEN_ONE);
              frame_start <= 1'b1;
            end
          end
        end

        GAP: begin
          if (gap_cnt == GAP_ONE) begin
            state       <= SEND;
            idx         <= len_q - LEN_ONE;
            ser_out     <= bit_at(pat_q, len_q - LEN_ONE);
            ser_valid   <= 1'b1;
            frame_start <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end

        DONE: begin
          state       <= IDLE;
          ser_out     <= 1'b0;
          ser_valid   <= 1'b0;
          frame_start <= 1'b0;
          busy        <= 1'b0;
          done        <= 1'b0;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_tx
//   Directed bench for seq_pattern_tx. Outputs are packed per cycle as
//   {ser_out, ser_valid, frame_start, busy, done} and compared against
//   hand-written per-cycle expectations. Cycle n is the cycle after edge n,
//   where edge 0 is the edge that accepts start; outputs are sampled on the
//   falling edge.
// -----------------------------------------------------------------------------
module tb_seq_pattern_tx;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] pattern;
  logic [3:0] pat_len;
  logic [7:0] reps;
  logic [3:0] gap;
  logic       abort;
  logic       ser_out;
  logic       ser_valid;
  logic       frame_start;
  logic       busy;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] exp_q[$];
  logic [4:0] outs;

  assign outs = {ser_out, ser_valid, frame_start, busy, done};

  seq_pattern_tx #(
    .PAT_W(8),
    .LEN_W(4),
    .CNT_W(8),
    .GAP_W(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .pattern    (pattern),
    .pat_len    (pat_len),
    .reps       (reps),
    .gap        (gap),
    .abort      (abort),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .frame_start(frame_start),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Starts a transfer at edge 0 and checks cycles 1..exp_q.size().
  // st_at / ab_at: cycle in which a stray start / abort is driven (-1 = none,
  // ab_at = 0 drives abort together with the accepting start).
  task automatic run_vec(input string tag, input logic [7:0] p, input logic [3:0] l,
                         input logic [7:0] r, input logic [3:0] g,
                         input int st_at, input int ab_at);
    @(negedge clk);
    start   = 1'b1;
    pattern = p;
    pat_len = l;
    reps    = r;
    gap     = g;
    abort   = (ab_at == 0);
    @(negedge clk);
    // Scramble inputs after acceptance; the latched copy must be used.
    start   = 1'b0;
    abort   = 1'b0;
    pattern = ~p;
    pat_len = 4'd2;
    reps    = 8'd7;
    gap     = 4'd1;
    for (int c = 1; c <= exp_q.size(); c++) begin
      chk($sformatf("%s c%0d", tag, c), {27'd0, outs}, {27'd0, exp_q[c-1]});
      start = (c == st_at);
      abort = (c == ab_at);
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    int nvalid;
    int nfs;
    int ndone_cyc;
    int nzero;

    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = 8'h00;
    pat_len = 4'd0;
    reps    = 8'd0;
    gap     = 4'd0;

    repeat (2) @(negedge clk);
    chk("reset outs", {27'd0, outs}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle outs", {27'd0, outs}, 32'd0);

    // T1: 1011 once
    exp_q = '{5'b11110, 5'b01010, 5'b11010, 5'b11010, 5'b00001, 5'b00000};
    run_vec("T1", 8'h0B, 4'd4, 8'd1, 4'd0, -1, -1);

    // T2: 101 three times back-to-back
    exp_q = '{5'b11110, 5'b01010, 5'b11010, 5'b11110, 5'b01010, 5'b11010,
              5'b11110, 5'b01010, 5'b11010, 5'b00001, 5'b00000};
    run_vec("T2", 8'h05, 4'd3, 8'd3, 4'd0, -1, -1);

    // T3: 1011 twice with a 2-cycle gap
    exp_q = '{5'b11110, 5'b01010, 5'b11010, 5'b11010, 5'b00010, 5'b00010,
              5'b11110, 5'b01010, 5'b11010, 5'b11010, 5'b00001, 5'b00000};
    run_vec("T3", 8'h0B, 4'd4, 8'd2, 4'd2, -1, -1);

    // T4a: reps=0 only pulses done
    exp_q = '{5'b00001, 5'b00000, 5'b00000};
    run_vec("T4a", 8'h0B, 4'd4, 8'd0, 4'd0, -1, -1);

    // T4b: pat_len=0 sends all 8 bits of A5
    exp_q = '{5'b11110, 5'b01010, 5'b11010, 5'b01010, 5'b01010, 5'b11010,
              5'b01010, 5'b11010, 5'b00001, 5'b00000};
    run_vec("T4b", 8'hA5, 4'd0, 8'd1, 4'd0, -1, -1);

    // pat_len=9 (> PAT_W) also means 8 bits: C3 = 11000011
    exp_q = '{5'b11110, 5'b11010, 5'b01010, 5'b01010, 5'b01010, 5'b01010,
              5'b11010, 5'b11010, 5'b00001, 5'b00000};
    run_vec("LEN9", 8'hC3, 4'd9, 8'd1, 4'd0, -1, -1);

    // T5: stray start in cycle 2 ignored, abort in cycle 3 kills the frame
    exp_q = '{5'b11110, 5'b01010, 5'b11010, 5'b00000, 5'b00000, 5'b00000};
    run_vec("T5", 8'h0B, 4'd4, 8'd1, 4'd0, 2, 3);

    // start and abort together in IDLE: nothing happens
    exp_q = '{5'b00000, 5'b00000, 5'b00000};
    run_vec("SA", 8'h0B, 4'd4, 8'd1, 4'd0, -1, 0);

    // reps=255, one-bit pattern: exactly 255 frames, no counter wrap
    @(negedge clk);
    start   = 1'b1;
    pattern = 8'h01;
    pat_len = 4'd1;
    reps    = 8'd255;
    gap     = 4'd0;
    @(negedge clk);
    start     = 1'b0;
    nvalid    = 0;
    nfs       = 0;
    nzero     = 0;
    ndone_cyc = -1;
    for (int c = 1; c <= 400; c++) begin
      if (ser_valid) nvalid++;
      if (frame_start) nfs++;
      if (ser_valid && !ser_out) nzero++;
      if (done) begin
        ndone_cyc = c;
        break;
      end
      @(negedge clk);
    end
    chk("R255 valid", nvalid, 255);
    chk("R255 fs", nfs, 255);
    chk("R255 zero bits", nzero, 0);
    chk("R255 done cyc", ndone_cyc, 256);
    @(negedge clk);

    // T6: async reset in the middle of T2, then a clean T1
    @(negedge clk);
    start   = 1'b1;
    pattern = 8'h05;
    pat_len = 4'd3;
    reps    = 8'd3;
    gap     = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("T6 pre-reset", {27'd0, outs}, {27'd0, 5'b01010});
    #2 rst_n = 1'b0;
    #1 chk("T6 async reset", {27'd0, outs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nzero = 0;
    repeat (12) begin
      @(negedge clk);
      if (outs != 5'b00000) nzero++;
    end
    chk("T6 no resume", nzero, 0);
    exp_q = '{5'b11110, 5'b01010, 5'b11010, 5'b11010, 5'b00001, 5'b00000};
    run_vec("T6 T1", 8'h0B, 4'd4, 8'd1, 4'd0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
